// File: rtl/wb_debug_master_if.sv
// Wishbone single-transaction bus bundle between the debug bridge (master) and the fabric (slave).
`timescale 1ns/1ps
interface wb_debug_master_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  modport master (output cyc, stb, we, adr, sel, dat_o, input dat_i, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_o, output dat_i, ack);
endinterface

// File: rtl/wb_debug_master.sv
// Byte-stream to Wishbone debug bridge: 0x52 read / 0x57 write commands become single bus cycles.
// Optional bus-ack timeout is built only when DBGM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module wb_debug_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  wb_debug_master_if.master       bus,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;

  localparam logic [BW-1:0] CMD_RD = 8'h52;
  localparam logic [BW-1:0] CMD_WR = 8'h57;
  localparam logic [BW-1:0] RSP_OK = 8'h4B;
  localparam logic [BW-1:0] RSP_TO = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_e;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("wb_debug_master: TIMEOUT must be nonzero");
  end

`ifdef DBGM_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_q;
`endif

  state_e          state_q;
  logic [1:0]      cnt_q;
  logic [1:0]      last_q;
  logic            is_wr_q;
  logic            cyc_q;
  logic            stb_q;
  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [3:0]      sel_q;
  logic [DW-1:0]   wdat_q;
  logic [DW-1:0]   rsp_q;
  logic [BW-1:0]   tx_data_q;
  logic            tx_valid_q;
  logic            busy_q;

  // Command decode, bus cycle and response serialisation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      is_wr_q    <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      wdat_q     <= '0;
      rsp_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DBGM_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
`ifdef DBGM_TIMEOUT_EN
      if (state_q != S_BUS) tmo_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (rx_valid && (rx_data == CMD_RD || rx_data == CMD_WR)) begin
            is_wr_q <= (rx_data == CMD_WR);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            adr_q <= {adr_q[AW-BW-1:0], rx_data};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= S_DATA;
              end else begin
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
                sel_q   <= 4'hF;
                state_q <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            wdat_q <= {wdat_q[DW-BW-1:0], rx_data};
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
              sel_q   <= 4'hF;
              state_q <= S_BUS;
            end
          end
        end

        S_BUS: begin
          if (bus.ack) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            tx_valid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_RESP;
            if (is_wr_q) begin
              tx_data_q <= RSP_OK;
              last_q    <= 2'd0;
            end else begin
              tx_data_q <= bus.dat_i[DW-1:DW-BW];
              rsp_q     <= {bus.dat_i[DW-BW-1:0], 8'h00};
              last_q    <= 2'd3;
            end
          end
`ifdef DBGM_TIMEOUT_EN
          // Abandon the cycle after TIMEOUT unacknowledged strobe cycles.
          else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= RSP_TO;
            last_q     <= 2'd0;
            cnt_q      <= '0;
            state_q    <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end

        S_RESP: begin
          if (tx_ready) begin
            if (cnt_q == last_q) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              tx_data_q <= rsp_q[DW-1:DW-BW];
              rsp_q     <= {rsp_q[DW-BW-1:0], 8'h00};
              cnt_q     <= cnt_q + 2'd1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cyc   = cyc_q;
  assign bus.stb   = stb_q;
  assign bus.we    = we_q;
  assign bus.adr   = adr_q;
  assign bus.sel   = sel_q;
  assign bus.dat_o = wdat_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;

endmodule
